// File: rtl/otn_frame_pkg.sv
// Shared OTN framing constants, FSM encodings and the CRC-8 byte step
// used by both the mapper and the receiver.
package otn_frame_pkg;

  localparam logic [7:0] FAS0_BYTE    = 8'hF6;
  localparam logic [7:0] FAS1_BYTE    = 8'h28;
  localparam logic [7:0] ACK_BYTE     = 8'h06;
  localparam logic [7:0] NAK_BYTE     = 8'h15;
  localparam logic [7:0] CRC_POLY     = 8'h07;
  // CRC-8 of payload bytes 0x01..0x10 (16 bytes)
  localparam logic [7:0] CRC_TEST_VEC = 8'hB0;

  typedef enum logic [1:0] {HUNT, FAS1, PYLD, CHK} frame_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/otn_frame_receiver_line_byte_uart.sv
// Generic 8N1 byte serdes: independent RX and TX halves sharing one bit-rate
// parameter, so the same block serves as line receiver and ack transmitter.
module line_byte_uart
  import otn_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       rx_err,
  input  logic       tx_req,
  input  logic [7:0] tx_byte,
  output logic       tx_line,
  output logic       tx_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          prev;
  logic          s;
  rx_state_t     rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_sh, rx_sh_n, rx_byte_n;
  logic          rx_vld_n, rx_err_n;

  tx_state_t     tx_st, tx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [3:0]    tx_nbit, tx_nbit_n;
  logic [9:0]    tx_frm, tx_frm_n;
  logic          tx_line_n;

  assign s       = sync[1];
  assign tx_busy = (tx_st == TX_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '1;
      prev    <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_idx  <= '0;
      rx_sh   <= '0;
      rx_byte <= '0;
      rx_vld  <= 1'b0;
      rx_err  <= 1'b0;
      tx_st   <= TX_IDLE;
      tx_cnt  <= '0;
      tx_nbit <= '0;
      tx_frm  <= '1;
      tx_line <= 1'b1;
    end else begin
      sync    <= {sync[0], rx_line};
      prev    <= s;
      rx_st   <= rx_st_n;
      rx_cnt  <= rx_cnt_n;
      rx_idx  <= rx_idx_n;
      rx_sh   <= rx_sh_n;
      rx_byte <= rx_byte_n;
      rx_vld  <= rx_vld_n;
      rx_err  <= rx_err_n;
      tx_st   <= tx_st_n;
      tx_cnt  <= tx_cnt_n;
      tx_nbit <= tx_nbit_n;
      tx_frm  <= tx_frm_n;
      tx_line <= tx_line_n;
    end
  end

  always_comb begin
    rx_st_n   = rx_st;
    rx_cnt_n  = rx_cnt;
    rx_idx_n  = rx_idx;
    rx_sh_n   = rx_sh;
    rx_byte_n = rx_byte;
    rx_vld_n  = 1'b0;
    rx_err_n  = 1'b0;
    case (rx_st)
      RX_IDLE: begin
        if (prev && !s) begin
          rx_cnt_n = '0;
          rx_st_n  = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF) begin
          rx_cnt_n = '0;
          if (s) begin
            rx_err_n = 1'b1;
            rx_st_n  = RX_IDLE;
          end else begin
            rx_idx_n = '0;
            rx_st_n  = RX_DATA;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {s, rx_sh[7:1]};
          if (rx_idx == 3'd7) rx_st_n = RX_STOP;
          else                rx_idx_n = rx_idx + 1'b1;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_st_n  = RX_IDLE;
          if (s) begin
            rx_vld_n  = 1'b1;
            rx_byte_n = rx_sh;
          end else begin
            rx_err_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  // TX shifts a {stop, data, start} frame out LSB-first; requests are only
  // accepted while idle.
  always_comb begin
    tx_st_n   = tx_st;
    tx_cnt_n  = tx_cnt;
    tx_nbit_n = tx_nbit;
    tx_frm_n  = tx_frm;
    case (tx_st)
      TX_IDLE: begin
        if (tx_req) begin
          tx_frm_n  = {1'b1, tx_byte, 1'b0};
          tx_cnt_n  = '0;
          tx_nbit_n = '0;
          tx_st_n   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          if (tx_nbit == 4'd9) begin
            tx_st_n = TX_IDLE;
          end else begin
            tx_frm_n  = {1'b1, tx_frm[9:1]};
            tx_nbit_n = tx_nbit + 1'b1;
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: tx_st_n = TX_IDLE;
    endcase
    tx_line_n = (tx_st_n == TX_SEND) ? tx_frm_n[0] : 1'b1;
  end

endmodule

// File: rtl/otn_frame_receiver.sv
// OTN line receiver: deserialises 8N1 bytes, hunts FAS, streams payload,
// checks the trailing CRC-8 and optionally returns ACK/NAK on the ack line.
module otn_frame_receiver
  import otn_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PYLD_BYTES   = 16,
  parameter int unsigned TIMEOUT_CYC  = 1 << 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_otn_rx_data,
  output logic       o_otn_tx_ack,
  input  logic       i_arq_en,
  output logic [7:0] o_pyld_data,
  output logic       o_pyld_valid,
  output logic       o_frame_good,
  output logic       o_frame_bad,
  output logic       o_line_err,
  output logic [7:0] o_crc_val
);

  localparam int unsigned PCW = $clog2(PYLD_BYTES + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PCW-1:0] PLAST = PCW'(PYLD_BYTES - 1);
  localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT_CYC - 1);

  logic [7:0]     rx_byte;
  logic           byte_vld, rx_err;
  logic           ack_busy;
  logic           rx_tx_line_unused, rx_tx_busy_unused;
  logic [7:0]     tx_rx_byte_unused;
  logic           tx_rx_vld_unused, tx_rx_err_unused;

  frame_state_t   state, state_n;
  logic [PCW-1:0] pcnt, pcnt_n;
  logic [TCW-1:0] tmo, tmo_n;
  logic [7:0]     crc, crc_n, crc_val, crc_val_n;
  logic           good, good_n, bad, bad_n;
  logic           ack_req, ack_req_n;
  logic [7:0]     ack_byte, ack_byte_n;
  logic           emitted, abort, match;

  line_byte_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (i_clk),
    .rst     (i_rst),
    .rx_line (i_otn_rx_data),
    .rx_byte (rx_byte),
    .rx_vld  (byte_vld),
    .rx_err  (rx_err),
    .tx_req  (1'b0),
    .tx_byte (8'h00),
    .tx_line (rx_tx_line_unused),
    .tx_busy (rx_tx_busy_unused)
  );

  line_byte_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk     (i_clk),
    .rst     (i_rst),
    .rx_line (1'b1),
    .rx_byte (tx_rx_byte_unused),
    .rx_vld  (tx_rx_vld_unused),
    .rx_err  (tx_rx_err_unused),
    .tx_req  (ack_req),
    .tx_byte (ack_byte),
    .tx_line (o_otn_tx_ack),
    .tx_busy (ack_busy)
  );

  assign o_pyld_data  = rx_byte;
  assign o_pyld_valid = byte_vld && (state == PYLD);
  assign o_frame_good = good;
  assign o_frame_bad  = bad;
  assign o_line_err   = rx_err;
  assign o_crc_val    = crc_val;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= HUNT;
      pcnt     <= '0;
      tmo      <= '0;
      crc      <= '0;
      crc_val  <= '0;
      good     <= 1'b0;
      bad      <= 1'b0;
      ack_req  <= 1'b0;
      ack_byte <= '0;
    end else begin
      state    <= state_n;
      pcnt     <= pcnt_n;
      tmo      <= tmo_n;
      crc      <= crc_n;
      crc_val  <= crc_val_n;
      good     <= good_n;
      bad      <= bad_n;
      ack_req  <= ack_req_n;
      ack_byte <= ack_byte_n;
    end
  end

  // An abort only reports a bad frame once payload has reached the sink.
  always_comb begin
    state_n    = state;
    pcnt_n     = pcnt;
    crc_n      = crc;
    crc_val_n  = crc_val;
    tmo_n      = '0;
    good_n     = 1'b0;
    bad_n      = 1'b0;
    ack_req_n  = 1'b0;
    ack_byte_n = ack_byte;
    match      = (rx_byte == crc);
    emitted    = (state == CHK) || ((state == PYLD) && (pcnt != '0));
    abort      = (state != HUNT) && (rx_err || ((tmo == TLAST) && !byte_vld));
    if (state != HUNT) tmo_n = byte_vld ? '0 : tmo + 1'b1;
    if (abort) begin
      state_n = HUNT;
      tmo_n   = '0;
      if (emitted) begin
        bad_n      = 1'b1;
        ack_req_n  = i_arq_en;
        ack_byte_n = NAK_BYTE;
      end
    end else if (byte_vld) begin
      case (state)
        HUNT: if (rx_byte == FAS0_BYTE) state_n = FAS1;
        FAS1: begin
          if (rx_byte == FAS1_BYTE) begin
            state_n = PYLD;
            crc_n   = '0;
            pcnt_n  = '0;
          end else if (rx_byte != FAS0_BYTE) begin
            state_n = HUNT;
          end
        end
        PYLD: begin
          crc_n  = crc8_byte(crc, rx_byte);
          pcnt_n = pcnt + 1'b1;
          if (pcnt == PLAST) state_n = CHK;
        end
        CHK: begin
          crc_val_n  = crc;
          good_n     = match;
          bad_n      = !match;
          ack_req_n  = i_arq_en;
          ack_byte_n = match ? ACK_BYTE : NAK_BYTE;
          state_n    = HUNT;
        end
        default: state_n = HUNT;
      endcase
    end
  end

  ack_overlap: assert property (@(posedge i_clk) disable iff (i_rst) !(ack_req && ack_busy));

endmodule

// File: tb/tb_otn_frame_receiver.sv
// Directed bench for otn_frame_receiver: queue-based scoreboard for payload,
// frame verdicts and serial ack bytes.
module tb_otn_frame_receiver;

  localparam int CLKS = 16;
  localparam int NPL  = 16;
  localparam int TMO  = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       arq = 1'b1;
  logic       ack;
  logic [7:0] pdata;
  logic       pvalid, fgood, fbad, lerr;
  logic [7:0] crcval;

  typedef struct packed {
    logic       good;
    logic       bad;
    logic       chk;
    logic [7:0] crc;
  } evt_t;

  logic [7:0] exp_pyld[$];
  logic [7:0] exp_ack[$];
  evt_t       exp_evt[$];
  int n_cmp = 0;
  int n_mis = 0;
  int lerr_seen = 0;
  int lerr_exp = 0;

  always #5 clk = ~clk;

  otn_frame_receiver #(.CLKS_PER_BIT(CLKS), .PYLD_BYTES(NPL), .TIMEOUT_CYC(TMO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_otn_rx_data (rx),
    .o_otn_tx_ack  (ack),
    .i_arq_en      (arq),
    .o_pyld_data   (pdata),
    .o_pyld_valid  (pvalid),
    .o_frame_good  (fgood),
    .o_frame_bad   (fbad),
    .o_line_err    (lerr),
    .o_crc_val     (crcval)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Bit-serial LFSR form of CRC-8 0x07, MSB first.
  function automatic logic [7:0] crc_step(input logic [7:0] r, input logic [7:0] b);
    logic [7:0] x;
    logic fb;
    x = r;
    for (int i = 7; i >= 0; i--) begin
      fb = x[7] ^ b[i];
      x  = {x[6:0], 1'b0};
      if (fb) x = x ^ 8'h07;
    end
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic send_payload_crc(input logic [7:0] base, input logic corrupt, input logic want_ack);
    logic [7:0] c;
    logic [7:0] p;
    c = 8'h00;
    for (int i = 0; i < NPL; i++) begin
      p = base + 8'(i);
      exp_pyld.push_back(p);
      c = crc_step(c, p);
      send_byte(p, 1'b1);
    end
    exp_evt.push_back('{good: !corrupt, bad: corrupt, chk: 1'b1, crc: c});
    if (want_ack) exp_ack.push_back(corrupt ? 8'h15 : 8'h06);
    send_byte(corrupt ? (c ^ 8'h01) : c, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] base, input logic corrupt, input logic want_ack);
    send_byte(8'hF6, 1'b1);
    send_byte(8'h28, 1'b1);
    send_payload_crc(base, corrupt, want_ack);
  endtask

  task automatic settle_and_drain(input string tag);
    repeat (14 * CLKS) @(negedge clk);
    check({tag, "_pyld_left"}, exp_pyld.size(), 0);
    check({tag, "_evt_left"}, exp_evt.size(), 0);
    check({tag, "_ack_left"}, exp_ack.size(), 0);
    check({tag, "_line_err"}, lerr_seen, lerr_exp);
  endtask

  always @(negedge clk) begin
    if (pvalid === 1'b1) begin
      if (exp_pyld.size() == 0) begin
        n_cmp++;
        n_mis++;
        $error("FAIL pyld_unexpected: observed %0h expected no strobe", pdata);
      end else begin
        check("pyld_data", pdata, exp_pyld.pop_front());
      end
    end
    if (lerr === 1'b1) lerr_seen++;
    if (fgood === 1'b1 || fbad === 1'b1) begin
      if (exp_evt.size() == 0) begin
        n_cmp++;
        n_mis++;
        $error("FAIL evt_unexpected: observed good=%0b bad=%0b expected none", fgood, fbad);
      end else begin
        evt_t e;
        e = exp_evt.pop_front();
        check("frame_good", fgood, e.good);
        check("frame_bad", fbad, e.bad);
        if (e.chk) check("crc_val", crcval, e.crc);
      end
    end
  end

  always begin
    logic [7:0] d;
    @(negedge ack);
    repeat (CLKS / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CLKS) @(negedge clk);
      d[i] = ack;
    end
    repeat (CLKS) @(negedge clk);
    check("ack_stop", ack, 1'b1);
    if (exp_ack.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL ack_unexpected: observed %0h expected idle line", d);
    end else begin
      check("ack_byte", d, exp_ack.pop_front());
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_ack", ack, 1'b1);
    check("rst_pdata", pdata, 8'h00);
    check("rst_crc", crcval, 8'h00);
    check("rst_pulses", {pvalid, fgood, fbad, lerr}, 4'b0000);
    rst = 1'b0;
    repeat (4 * CLKS) @(negedge clk);

    // 1: clean frame 01..10 with ACK
    send_frame(8'h01, 1'b0, 1'b1);
    settle_and_drain("t1");

    // 2: corrupted CRC byte -> bad + NAK
    send_frame(8'h01, 1'b1, 1'b1);
    settle_and_drain("t2");

    // 3: garbage, lock on second F6/28
    send_byte(8'h00, 1'b1);
    send_byte(8'hF6, 1'b1);
    send_byte(8'hF6, 1'b1);
    send_byte(8'h28, 1'b1);
    send_payload_crc(8'h20, 1'b0, 1'b1);
    settle_and_drain("t3");

    // 4: stop bit 0 on payload byte 5, then the frame remainder, then clean
    send_byte(8'hF6, 1'b1);
    send_byte(8'h28, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      exp_pyld.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    lerr_exp++;
    exp_evt.push_back('{good: 1'b0, bad: 1'b1, chk: 1'b0, crc: 8'h00});
    exp_ack.push_back(8'h15);
    send_byte(8'h05, 1'b0);
    for (int i = 6; i <= NPL; i++) send_byte(8'(i), 1'b1);
    send_byte(8'hB0, 1'b1);
    settle_and_drain("t4a");
    send_frame(8'h30, 1'b0, 1'b1);
    // drop arq_en while the ACK is still on the wire
    repeat (2 * CLKS) @(negedge clk);
    arq = 1'b0;
    settle_and_drain("t4b");

    // 5: arq disabled, good then bad, ack line must stay idle
    send_frame(8'h40, 1'b0, 1'b0);
    send_frame(8'h50, 1'b1, 1'b0);
    settle_and_drain("t5");
    check("t5_ack_idle", ack, 1'b1);

    // 6: reset mid-payload, then clean frame
    arq = 1'b1;
    send_byte(8'hF6, 1'b1);
    send_byte(8'h28, 1'b1);
    for (int i = 0; i < 5; i++) begin
      exp_pyld.push_back(8'h70 + 8'(i));
      send_byte(8'h70 + 8'(i), 1'b1);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_ack", ack, 1'b1);
    check("t6_rst_crc", crcval, 8'h00);
    check("t6_rst_pdata", pdata, 8'h00);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CLKS) @(negedge clk);
    send_frame(8'h60, 1'b0, 1'b1);
    settle_and_drain("t6");

    // 7: inter-byte timeout after 3 payload bytes -> bad + NAK
    send_byte(8'hF6, 1'b1);
    send_byte(8'h28, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_pyld.push_back(8'h80 + 8'(i));
      send_byte(8'h80 + 8'(i), 1'b1);
    end
    exp_evt.push_back('{good: 1'b0, bad: 1'b1, chk: 1'b0, crc: 8'h00});
    exp_ack.push_back(8'h15);
    repeat (TMO + 2 * CLKS) @(negedge clk);
    settle_and_drain("t7");

    // 8: false start while in FAS1 -> line_err only, then clean frame
    send_byte(8'hF6, 1'b1);
    lerr_exp++;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    send_frame(8'h90, 1'b0, 1'b1);
    settle_and_drain("t8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
